// File: rtl/adv_pkg.sv
// Shared types and constants for the adventure-game room sequencer.
// Rooms are one-hot; bit order [6:0] = GRAVE, VICTORY, DEN, STASH, RIVER, TUNNEL, CAVE.
package adv_pkg;

    localparam int unsigned ROOM_COUNT = 7;

    localparam int unsigned N = 0;
    localparam int unsigned S = 1;
    localparam int unsigned E = 2;
    localparam int unsigned W = 3;

    typedef enum logic [ROOM_COUNT-1:0] {
        CAVE    = 7'b0000001,
        TUNNEL  = 7'b0000010,
        RIVER   = 7'b0000100,
        STASH   = 7'b0001000,
        DEN     = 7'b0010000,
        VICTORY = 7'b0100000,
        GRAVE   = 7'b1000000
    } room_t;

endpackage

// File: rtl/dir_edge.sv
// Rising-edge detector for the four direction buttons.
// Flags a valid move only when exactly one new press appears in a cycle.
module dir_edge
    import adv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    output logic [3:0] press,
    output logic       valid
);

    logic [3:0] prev;

    // prev follows the buttons during reset too, so a button held through reset never fires
    always_ff @(posedge clk) begin
        prev <= btn;
    end

    always_comb begin
        press = reset ? '0 : (btn & ~prev);
        valid = $onehot(press);
    end

endmodule

// File: rtl/room_ctrl.sv
// Room-sequencing controller: tracks the player's room from button presses,
// requests the sword pickup, resolves the dragon and counts accepted moves.
module room_ctrl
    import adv_pkg::*;
#(
    parameter int unsigned MOVE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  n,
    input  logic                  s,
    input  logic                  e,
    input  logic                  w,
    input  logic                  has_sword,
    output logic                  sw,
    output logic [ROOM_COUNT-1:0] room,
    output logic                  win,
    output logic                  dead,
    output logic [MOVE_W-1:0]     move_cnt
);

    logic [3:0] btn;
    logic [3:0] press;
    logic       valid;
    room_t      state;

    assign btn = {w, e, s, n};

    dir_edge u_dir_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .press (press),
        .valid (valid)
    );

    function automatic logic [MOVE_W-1:0] sat_inc(input logic [MOVE_W-1:0] v);
        return (v == '1) ? v : v + MOVE_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CAVE;
            move_cnt <= '0;
        end else begin
            case (state)
                CAVE: begin
                    if (valid && press[E]) begin
                        state    <= TUNNEL;
                        move_cnt <= sat_inc(move_cnt);
                    end
                end
                TUNNEL: begin
                    if (valid && press[W]) begin
                        state    <= CAVE;
                        move_cnt <= sat_inc(move_cnt);
                    end else if (valid && press[S]) begin
                        state    <= RIVER;
                        move_cnt <= sat_inc(move_cnt);
                    end
                end
                RIVER: begin
                    if (valid && press[N]) begin
                        state    <= TUNNEL;
                        move_cnt <= sat_inc(move_cnt);
                    end else if (valid && press[W]) begin
                        state    <= STASH;
                        move_cnt <= sat_inc(move_cnt);
                    end else if (valid && press[E]) begin
                        state    <= DEN;
                        move_cnt <= sat_inc(move_cnt);
                    end
                end
                STASH: begin
                    if (valid && press[E]) begin
                        state    <= RIVER;
                        move_cnt <= sat_inc(move_cnt);
                    end
                end
                // The dragon is resolved on the single DEN cycle; this exit is not a counted move
                DEN:     state <= has_sword ? VICTORY : GRAVE;
                VICTORY: state <= VICTORY;
                GRAVE:   state <= GRAVE;
                default: state <= CAVE;
            endcase
        end
    end

    always_comb begin
        room = state;
        sw   = (state == STASH);
        win  = (state == VICTORY);
        dead = (state == GRAVE);
    end

endmodule

// File: tb/tb_room_ctrl.sv
// Self-checking bench for room_ctrl: vector table, directed corner sequences and
// randomized stimulus against a room-index reference model with the sword latch in loop.
module tb_room_ctrl;

    logic       clk;
    logic       reset;
    logic       n, s, e, w;
    logic       has_sword, has_sword3;
    logic       sw, sw3;
    logic [6:0] room, room3;
    logic       win, win3, dead, dead3;
    logic [7:0] move_cnt;
    logic [2:0] move_cnt3;

    int total = 0;
    int bad   = 0;

    room_ctrl #(.MOVE_W(8)) dut (
        .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
        .has_sword(has_sword), .sw(sw), .room(room), .win(win), .dead(dead),
        .move_cnt(move_cnt)
    );

    room_ctrl #(.MOVE_W(3)) dut3 (
        .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
        .has_sword(has_sword3), .sw(sw3), .room(room3), .win(win3), .dead(dead3),
        .move_cnt(move_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sword item latches: set by the pickup request, cleared only by global reset
    always @(posedge clk) begin
        if (reset) has_sword <= 1'b0;
        else if (sw) has_sword <= 1'b1;
    end
    always @(posedge clk) begin
        if (reset) has_sword3 <= 1'b0;
        else if (sw3) has_sword3 <= 1'b1;
    end

    // Reference model: rooms as indices 0..6 (CAVE,TUNNEL,RIVER,STASH,DEN,VICTORY,GRAVE),
    // directions 0..3 (n,s,e,w), a move table and plain counters.
    int       tbl [7][4];
    int       m_room;
    int       m_cnt;
    bit       m_sword;
    bit [3:0] m_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit [3:0] b);
        bit [3:0] pr;
        int       old;
        int       d;
        if (r) begin
            m_room  = 0;
            m_cnt   = 0;
            m_sword = 0;
            m_prev  = b;
            return;
        end
        pr     = b & ~m_prev;
        m_prev = b;
        old    = m_room;
        if (old == 4) begin
            m_room = m_sword ? 5 : 6;
        end else if ($countones(pr) == 1) begin
            d = 0;
            for (int i = 0; i < 4; i++) if (pr[i]) d = i;
            if (tbl[old][d] >= 0) begin
                m_room = tbl[old][d];
                if (m_cnt < 255) m_cnt++;
            end
        end
        if (old == 3) m_sword = 1;
    endtask

    task automatic tick(input bit r, input bit [3:0] b);
        reset = r;
        {w, e, s, n} = b;
        @(posedge clk);
        model_step(r, b);
        #1;
        chk("room",    room,      32'(1) << m_room);
        chk("cnt",     move_cnt,  m_cnt);
        chk("cnt3",    move_cnt3, (m_cnt > 7) ? 7 : m_cnt);
        chk("sw",      sw,        m_room == 3);
        chk("win",     win,       m_room == 5);
        chk("dead",    dead,      m_room == 6);
        chk("room3",   room3,     32'(1) << m_room);
    endtask

    typedef struct {
        bit         rst;
        bit [3:0]   btn;   // {w,e,s,n}
        logic [6:0] room;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs [17];

    initial begin
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 4; j++) tbl[i][j] = -1;
        tbl[0][2] = 1;
        tbl[1][3] = 0; tbl[1][1] = 2;
        tbl[2][0] = 1; tbl[2][3] = 3; tbl[2][2] = 4;
        tbl[3][2] = 2;
        m_room = 0; m_cnt = 0; m_sword = 0; m_prev = '0;

        vecs = '{
            '{1, 4'b0000, 7'b0000001, 8'd0},
            '{0, 4'b0100, 7'b0000010, 8'd1},
            '{0, 4'b0000, 7'b0000010, 8'd1},
            '{0, 4'b0010, 7'b0000100, 8'd2},
            '{0, 4'b0000, 7'b0000100, 8'd2},
            '{0, 4'b0100, 7'b0010000, 8'd3},
            '{0, 4'b0000, 7'b1000000, 8'd3},
            '{0, 4'b0100, 7'b1000000, 8'd3},
            '{0, 4'b0000, 7'b1000000, 8'd3},
            '{0, 4'b0001, 7'b1000000, 8'd3},
            '{1, 4'b0000, 7'b0000001, 8'd0},
            '{0, 4'b0001, 7'b0000001, 8'd0},
            '{0, 4'b0000, 7'b0000001, 8'd0},
            '{0, 4'b0100, 7'b0000010, 8'd1},
            '{0, 4'b0000, 7'b0000010, 8'd1},
            '{0, 4'b0110, 7'b0000010, 8'd1},
            '{0, 4'b0000, 7'b0000010, 8'd1}
        };

        reset = 1'b1; {w, e, s, n} = '0;
        tick(1, 4'b0000);
        chk("rst_room", room, 7'b0000001);
        chk("rst_cnt",  move_cnt, 8'd0);
        chk("rst_flags", {sw, win, dead}, 3'b000);

        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].btn);
            chk($sformatf("vec%0d_room", i), room, vecs[i].room);
            chk($sformatf("vec%0d_cnt", i), move_cnt, vecs[i].cnt);
        end

        // Sword path: e, s, w into STASH, then e, e through DEN to VICTORY
        tick(1, 4'b0000);
        tick(0, 4'b0100); tick(0, 4'b0000);
        tick(0, 4'b0010); tick(0, 4'b0000);
        tick(0, 4'b1000);
        chk("stash_sw", sw, 1'b1);
        chk("stash_sword_pending", has_sword, 1'b0);
        tick(0, 4'b0000);
        chk("stash_sword_set", has_sword, 1'b1);
        chk("stash_sw_dwell", sw, 1'b1);
        tick(0, 4'b0100);
        chk("leave_stash_sw", sw, 1'b0);
        tick(0, 4'b0000);
        tick(0, 4'b0100);
        chk("den_room", room, 7'b0010000);
        tick(0, 4'b0000);
        chk("victory_room", room, 7'b0100000);
        chk("victory_win", win, 1'b1);
        chk("victory_cnt", move_cnt, 8'd5);
        tick(0, 4'b1000);
        chk("victory_hold", room, 7'b0100000);
        tick(1, 4'b1000);
        chk("reset_from_victory", {room, sw, win, dead}, {7'b0000001, 3'b000});

        // Holding e for 10 cycles gives one move
        tick(0, 4'b0000);
        for (int i = 0; i < 10; i++) tick(0, 4'b0100);
        chk("hold_room", room, 7'b0000010);
        chk("hold_cnt", move_cnt, 8'd1);

        // e held across reset deassertion, then reset while in RIVER
        tick(1, 4'b0100); tick(1, 4'b0100);
        tick(0, 4'b0100);
        chk("held_reset_room", room, 7'b0000001);
        chk("held_reset_cnt", move_cnt, 8'd0);
        tick(0, 4'b0000); tick(0, 4'b0100);
        tick(0, 4'b0000); tick(0, 4'b0010);
        chk("river_room", room, 7'b0000100);
        tick(1, 4'b0001);
        chk("river_reset", {room, sw, move_cnt}, {7'b0000001, 1'b0, 8'd0});

        // Back-to-back e/w presses: ten moves, narrow counter saturates at 7
        tick(0, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            tick(0, 4'b0100);
            tick(0, 4'b1000);
        end
        chk("toggle_cnt", move_cnt, 8'd10);
        chk("sat_cnt3", move_cnt3, 3'd7);
        chk("toggle_room", room, 7'b0000001);

        // Randomized stimulus against the model
        for (int k = 0; k < 3000; k++) begin
            bit [3:0] b;
            int       sel;
            sel = int'($urandom % 8);
            case (sel)
                0, 1, 2, 3: b = 4'(1 << sel);
                4, 5:       b = '0;
                6:          b = 4'($urandom);
                default:    b = {w, e, s, n};
            endcase
            tick(($urandom % 60) == 0, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
